// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and the hard-wired zero register index.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Load-use hazard comparator: flags an ID source that depends on a load in EX.
// Purely combinational; writes to the zero register never create a dependency.
import pipeline_ctrl_pkg::*;

module hazard_detect #(
    parameter int unsigned REG_ADDR_BITS = 5
) (
    input  logic [REG_ADDR_BITS-1:0] id_rs1,
    input  logic [REG_ADDR_BITS-1:0] id_rs2,
    input  logic                     id_uses_rs1,
    input  logic                     id_uses_rs2,
    input  logic                     ex_mem_read,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    output logic                     load_use
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rd_nonzero = (ex_rd != REG_ADDR_BITS'(REG_ZERO));
        rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use   = ex_mem_read && rd_nonzero && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: memory-stall FSM with timeout, branch flush and load-use stall.
// Optional performance counters (stall_cycles, flush_count) when PIPE_PERF_CNT_EN is defined.
import pipeline_ctrl_pkg::*;

module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned CNT_BITS      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BITS-1:0] id_rs1,
    input  logic [REG_ADDR_BITS-1:0] id_rs2,
    input  logic                     id_uses_rs1,
    input  logic                     id_uses_rs2,
    input  logic                     ex_mem_read,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    input  logic                     branch_taken_ex,
    input  logic                     dmem_req,
    input  logic                     dmem_ready,
    output logic                     pc_write_en,
    output logic                     if_id_write_en,
    output logic                     if_id_clear_pipeline,
    output logic                     id_ex_clear_pipeline,
    output logic                     ex_mem_clear_pipeline,
    output logic                     mem_wb_clear_pipeline,
    output logic                     mem_error
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_BITS-1:0]      stall_cycles,
    output logic [CNT_BITS-1:0]      flush_count
`endif
);

    localparam int unsigned TMO_BITS = $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [TMO_BITS-1:0] tmo_q, tmo_d;
    logic                mem_error_q, mem_error_d;
    logic                load_use;
    logic                flush_evt;

    hazard_detect #(
        .REG_ADDR_BITS (REG_ADDR_BITS)
    ) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    always_comb begin
        state_d               = state_q;
        tmo_d                 = tmo_q;
        flush_evt             = 1'b0;
        pc_write_en           = 1'b1;
        if_id_write_en        = 1'b1;
        if_id_clear_pipeline  = 1'b0;
        id_ex_clear_pipeline  = 1'b0;
        ex_mem_clear_pipeline = 1'b0;
        mem_wb_clear_pipeline = 1'b0;

        unique case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    pc_write_en           = 1'b0;
                    if_id_write_en        = 1'b0;
                    if_id_clear_pipeline  = 1'b1;
                    id_ex_clear_pipeline  = 1'b1;
                    ex_mem_clear_pipeline = 1'b1;
                    mem_wb_clear_pipeline = 1'b1;
                    state_d               = MEM_WAIT;
                    tmo_d                 = TMO_BITS'(1);
                end else if (branch_taken_ex) begin
                    if_id_clear_pipeline = 1'b1;
                    id_ex_clear_pipeline = 1'b1;
                    flush_evt            = 1'b1;
                end else if (load_use) begin
                    pc_write_en          = 1'b0;
                    if_id_write_en       = 1'b0;
                    id_ex_clear_pipeline = 1'b1;
                end
            end
            MEM_WAIT: begin
                // A resolved branch stays parked in EX until the memory access completes.
                pc_write_en           = 1'b0;
                if_id_write_en        = 1'b0;
                if_id_clear_pipeline  = 1'b1;
                id_ex_clear_pipeline  = 1'b1;
                ex_mem_clear_pipeline = 1'b1;
                mem_wb_clear_pipeline = 1'b1;
                if (dmem_ready) begin
                    state_d = RUN;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_BITS'(MEM_TIMEOUT)) begin
                    state_d = MEM_ERR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_BITS'(1);
                end
            end
            MEM_ERR: begin
                pc_write_en           = 1'b0;
                if_id_write_en        = 1'b0;
                if_id_clear_pipeline  = 1'b1;
                id_ex_clear_pipeline  = 1'b1;
                ex_mem_clear_pipeline = 1'b1;
                mem_wb_clear_pipeline = 1'b1;
                state_d               = RUN;
            end
            default: begin
                state_d = RUN;
                tmo_d   = '0;
            end
        endcase

        if (rst) begin
            pc_write_en           = 1'b0;
            if_id_write_en        = 1'b0;
            if_id_clear_pipeline  = 1'b1;
            id_ex_clear_pipeline  = 1'b1;
            ex_mem_clear_pipeline = 1'b1;
            mem_wb_clear_pipeline = 1'b1;
        end

        mem_error_d = mem_error_q || (state_d == MEM_ERR);
        mem_error   = mem_error_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            tmo_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            mem_error_q <= mem_error_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_BITS-1:0] stall_q, stall_d;
    logic [CNT_BITS-1:0] flush_q, flush_d;

    always_comb begin
        stall_d      = pc_write_en ? stall_q : stall_q + CNT_BITS'(1);
        flush_d      = flush_evt ? flush_q + CNT_BITS'(1) : flush_q;
        stall_cycles = stall_q;
        flush_count  = flush_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller (MEM_TIMEOUT=4, CNT_BITS=4).
// Driver pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
    } vec_t;

    typedef struct {
        string      name;
        logic       pc;
        logic       ifid;
        logic [3:0] clr;
        logic       merr;
        logic       chk_cnt;
        logic [3:0] stall;
        logic [3:0] flush;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic       branch_taken_ex = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic       pc_write_en, if_id_write_en, mem_error;
    logic       if_id_clear_pipeline, id_ex_clear_pipeline;
    logic       ex_mem_clear_pipeline, mem_wb_clear_pipeline;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0] stall_cycles, flush_count;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_ADDR_BITS (5),
        .MEM_TIMEOUT   (4),
        .CNT_BITS      (4)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .id_rs1                (id_rs1),
        .id_rs2                (id_rs2),
        .id_uses_rs1           (id_uses_rs1),
        .id_uses_rs2           (id_uses_rs2),
        .ex_mem_read           (ex_mem_read),
        .ex_rd                 (ex_rd),
        .branch_taken_ex       (branch_taken_ex),
        .dmem_req              (dmem_req),
        .dmem_ready            (dmem_ready),
        .pc_write_en           (pc_write_en),
        .if_id_write_en        (if_id_write_en),
        .if_id_clear_pipeline  (if_id_clear_pipeline),
        .id_ex_clear_pipeline  (id_ex_clear_pipeline),
        .ex_mem_clear_pipeline (ex_mem_clear_pipeline),
        .mem_wb_clear_pipeline (mem_wb_clear_pipeline),
        .mem_error             (mem_error)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles          (stall_cycles),
        .flush_count           (flush_count)
`endif
    );

    // Monitor: compares one expectation per cycle, half a period after inputs settle.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [6:0] got;
        logic [6:0] want;
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            got  = {pc_write_en, if_id_write_en, if_id_clear_pipeline, id_ex_clear_pipeline,
                    ex_mem_clear_pipeline, mem_wb_clear_pipeline, mem_error};
            want = {e.pc, e.ifid, e.clr, e.merr};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc/ifid/clr[4]/merr=%b required=%b", e.name, got, want);
            end
`ifdef PIPE_PERF_CNT_EN
            if (e.chk_cnt) begin
                checks++;
                if (stall_cycles !== e.stall || flush_count !== e.flush) begin
                    errors++;
                    $display("FAIL %s_cnt: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                             e.name, stall_cycles, flush_count, e.stall, e.flush);
                end
            end
`endif
        end
    end

    task automatic step(input vec_t v, input string name, input logic pc, input logic ifid,
                        input logic [3:0] clr, input logic merr, input logic chk,
                        input logic [3:0] st, input logic [3:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = v.rst;
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_mem_read     = v.mr;
        ex_rd           = v.rd;
        branch_taken_ex = v.br;
        dmem_req        = v.req;
        dmem_ready      = v.rdy;
        e.name = name; e.pc = pc; e.ifid = ifid; e.clr = clr; e.merr = merr;
        e.chk_cnt = chk; e.stall = st; e.flush = fl;
        sb.push_back(e);
    endtask

    function automatic vec_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic mr,
                                input logic [4:0] rd, input logic br, input logic req,
                                input logic rdy);
        vec_t v;
        v = '{rst: r, rs1: rs1, rs2: rs2, u1: u1, u2: u2, mr: mr, rd: rd,
              br: br, req: req, rdy: rdy};
        return v;
    endfunction

    initial begin
        vec_t idle, lu2, lu2_z, lu1, lu1_nu, lu1_nl, br_lu, br_mem, mem_lo, mem_hi, br_only;
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu2     = mk(0, 0, 5, 0, 1, 1, 5, 0, 0, 0);
        lu2_z   = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        lu1     = mk(0, 7, 0, 1, 0, 1, 7, 0, 0, 0);
        lu1_nu  = mk(0, 7, 0, 0, 0, 1, 7, 0, 0, 0);
        lu1_nl  = mk(0, 7, 0, 1, 0, 0, 7, 0, 0, 0);
        br_lu   = mk(0, 0, 5, 0, 1, 1, 5, 1, 0, 0);
        br_mem  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        mem_lo  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        mem_hi  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        br_only = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "in_reset", 0, 0, 4'hF, 0, 1, 0, 0);
        step(idle,   "idle_run",       1, 1, 4'h0, 0, 0, 0, 0);
        step(lu2,    "loaduse_rs2",    0, 0, 4'b0100, 0, 1, 0, 0);
        step(lu2_z,  "loaduse_rd0",    1, 1, 4'h0, 0, 1, 1, 0);
        step(lu1,    "loaduse_rs1",    0, 0, 4'b0100, 0, 0, 0, 0);
        step(lu1_nu, "rs1_unused",     1, 1, 4'h0, 0, 1, 2, 0);
        step(lu1_nl, "ex_not_load",    1, 1, 4'h0, 0, 0, 0, 0);
        step(br_lu,  "branch_over_lu", 1, 1, 4'b1100, 0, 1, 2, 0);
        step(idle,   "after_branch",   1, 1, 4'h0, 0, 1, 2, 1);
        // Memory stall beats a branch; branch held during the wait is not a flush.
        step(br_mem, "mem_over_branch", 0, 0, 4'hF, 0, 1, 2, 1);
        step(br_mem, "mem_wait1",      0, 0, 4'hF, 0, 0, 0, 0);
        step(br_mem, "mem_wait2",      0, 0, 4'hF, 0, 0, 0, 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "mem_release", 0, 0, 4'hF, 0, 0, 0, 0);
        step(idle,   "after_release",  1, 1, 4'h0, 0, 1, 6, 1);
        step(mem_hi, "mem_hit",        1, 1, 4'h0, 0, 1, 6, 1);
        step(mem_lo, "tmo_enter",      0, 0, 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(mem_lo, "tmo_wait", 0, 0, 4'hF, 0, 0, 0, 0);
        step(idle,   "mem_err",        0, 0, 4'hF, 1, 1, 11, 1);
        step(idle,   "err_sticky1",    1, 1, 4'h0, 1, 1, 12, 1);
        step(idle,   "err_sticky2",    1, 1, 4'h0, 1, 0, 0, 0);
        // Ready arriving exactly at the timeout count still releases the wait.
        step(mem_lo, "race_enter",     0, 0, 4'hF, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(mem_lo, "race_wait", 0, 0, 4'hF, 1, 0, 0, 0);
        step(mem_hi, "race_ready",     0, 0, 4'hF, 1, 0, 0, 0);
        step(idle,   "race_run",       1, 1, 4'h0, 1, 1, 1, 1);
        step(mem_lo, "rst_enter",      0, 0, 4'hF, 1, 0, 0, 0);
        step(mem_lo, "rst_wait",       0, 0, 4'hF, 1, 0, 0, 0);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rst_mid_wait", 0, 0, 4'hF, 0, 1, 0, 0);
        step(idle,   "rst_released",   1, 1, 4'h0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(br_only, "flush", 1, 1, 4'b1100, 0, 0, 0, 0);
        step(idle,   "flush_wrap",     1, 1, 4'h0, 0, 1, 0, 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter REG_ADDR_BITS, default 5: width of register indices.
REQ-002 Parameter MEM_TIMEOUT, default 16: maximum cycles waiting for dmem_ready before error.
REQ-003 Parameter CNT_BITS, default 32: width of the performance counters.
REQ-004 Port clk  in  1: single clock, rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-high.
REQ-006 Ports id_rs1, id_rs2  in  REG_ADDR_BITS: source registers of the instruction in ID.
REQ-007 Ports id_uses_rs1, id_uses_rs2  in  1: the ID instruction reads rs1/rs2.
REQ-008 Port ex_mem_read  in  1: the EX instruction is a load.
REQ-009 Port ex_rd  in  REG_ADDR_BITS: destination register of the EX instruction.
REQ-010 Port branch_taken_ex  in  1: taken branch or jump resolved in EX.
REQ-011 Ports dmem_req, dmem_ready  in  1: MEM-stage data-memory request and completion.
REQ-012 Ports pc_write_en, if_id_write_en  out  1: PC / IF-ID update enables.
REQ-013 Ports if_id_clear_pipeline, id_ex_clear_pipeline, ex_mem_clear_pipeline, mem_wb_clear_pipeline  out  1: per-stage clear_pipeline (high = hold data, disable M/WB control).
REQ-014 Port mem_error  out  1: sticky memory-timeout flag.

Function
REQ-015 FSM states: RUN, MEM_WAIT, MEM_ERR. State is registered; outputs are combinational from state and current inputs.
REQ-016 Load-use hazard = ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
REQ-017 Default (RUN, no event): pc_write_en = if_id_write_en = 1, all clears 0.
REQ-018 Priority, highest first: memory stall, branch flush, load-use stall.
REQ-019 RUN, dmem_req && !dmem_ready: pc_write_en = if_id_write_en = 0; if_id, id_ex, ex_mem clears 1 (freeze); mem_wb_clear_pipeline 1 (bubble); next state MEM_WAIT, timeout counter loaded with 1.
REQ-020 RUN, branch_taken_ex (no memory stall): pc_write_en = 1, if_id_write_en = 1; if_id_clear_pipeline = id_ex_clear_pipeline = 1; load-use stall suppressed; stay RUN.
REQ-021 RUN, load-use hazard only: pc_write_en = if_id_write_en = 0, id_ex_clear_pipeline = 1 (one bubble); stay RUN.
REQ-022 MEM_WAIT: freeze outputs as REQ-019 every cycle; dmem_ready = 1 -> next RUN with freeze still applied in that cycle; branch_taken_ex ignored (it remains held in EX and is acted on after release).
REQ-023 MEM_WAIT: counter increments each cycle without dmem_ready; when counter == MEM_TIMEOUT and dmem_ready = 0 -> next MEM_ERR.
REQ-024 dmem_ready and timeout in the same cycle: dmem_ready wins, go RUN.
REQ-025 MEM_ERR lasts exactly one cycle: all four clears 1, pc_write_en = if_id_write_en = 0, mem_error set; next RUN.
REQ-026 mem_error remains 1 until reset.

Reset
REQ-027 rst = 1 asynchronously forces state RUN, timeout counter 0, mem_error 0, counters 0.
REQ-028 While rst = 1: pc_write_en = if_id_write_en = 0, all four clears 1.
REQ-029 Reset asserted in MEM_WAIT abandons the wait; the first cycle after release is RUN.

Configuration
REQ-030 Macro PIPE_PERF_CNT_EN defined: output ports stall_cycles and flush_count (CNT_BITS) are present; stall_cycles increments on every cycle with pc_write_en = 0 outside reset; flush_count increments on every REQ-020 flush; both wrap modulo 2^CNT_BITS.
REQ-031 PIPE_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Package pipeline_ctrl_pkg holds the state enum (RUN, MEM_WAIT, MEM_ERR) and the constant REG_ZERO = 0.
REQ-033 Load-use comparison is one combinational sub-module, hazard_detect; FSM, timeout counter and performance counters reside in pipeline_hazard_controller.

Verification
REQ-034 ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> for one cycle pc_write_en = 0, if_id_write_en = 0, id_ex_clear_pipeline = 1; ex_rd = 0 with same other inputs -> no stall.
REQ-035 branch_taken_ex = 1 and load-use hazard in the same cycle -> if_id and id_ex clears 1, pc_write_en = 1; stall_cycles unchanged.
REQ-036 dmem_req = 1, dmem_ready low for 3 cycles, then 1 -> 4 freeze cycles, mem_wb_clear_pipeline = 1 throughout, RUN afterwards, stall_cycles += 4.
REQ-037 MEM_TIMEOUT = 4, dmem_ready never asserted -> MEM_ERR after 4 wait cycles, all clears 1 for one cycle, mem_error = 1 until rst.
REQ-038 rst pulsed mid MEM_WAIT -> outputs immediately take reset values; after release state RUN, mem_error 0, counters 0.
REQ-039 CNT_BITS = 4, 17 branch flushes -> flush_count = 1 (wrap).
